// File: rtl/maze_engine_gen.sv
// maze_engine_gen: parametrised maze puzzle engine.
//
// The player walks a GRID_W x GRID_H maze chosen at random from NUM_MAPS mazes.
// The walls and the start/goal cells come from external synchronous ROMs, so the
// engine stores only the walls of the current cell.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   current_state_i         controller state (0 idle, 1 activating, 2 activated)
//   rnd_i                   free-running random word; bits [3:0] seed the map choice
//   btn_{u,d,l,r}_i         debounced one-cycle move pulses
//   wall_addr_o/wall_data_i wall ROM port. Data is {up, down, left, right}, 1 = wall
//   pos_addr_o/pos_data_i   position ROM port. Data is {start_y, start_x, goal_y, goal_x}
//   activated_o             sticky, set once map selection starts
//   module_failed_o         one-cycle pulse per illegal move or move-limit overrun
//   module_solved_o         sticky, set once the goal is reached
//   cur_*_o, goal_*_o       player and goal coordinates
//   move_count_o            legal moves in this attempt, saturating at 255
//   map_id_o                selected maze index
module maze_engine_gen #(
  parameter int unsigned GRID_W          = 8,
  parameter int unsigned GRID_H          = 8,
  parameter int unsigned NUM_MAPS        = 9,
  parameter int unsigned CW              = 4,
  parameter int unsigned MOVE_LIMIT      = 0,
  parameter int unsigned RESTART_ON_FAIL = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [2:0]      current_state_i,
  input  logic [31:0]     rnd_i,
  input  logic            btn_u_i,
  input  logic            btn_d_i,
  input  logic            btn_l_i,
  input  logic            btn_r_i,
  output logic [11:0]     wall_addr_o,
  input  logic [3:0]      wall_data_i,
  output logic [3:0]      pos_addr_o,
  input  logic [4*CW-1:0] pos_data_i,
  output logic            activated_o,
  output logic            module_failed_o,
  output logic            module_solved_o,
  output logic [CW-1:0]   cur_x_o,
  output logic [CW-1:0]   cur_y_o,
  output logic [CW-1:0]   goal_x_o,
  output logic [CW-1:0]   goal_y_o,
  output logic [7:0]      move_count_o,
  output logic [3:0]      map_id_o
);

  localparam logic [2:0]    CsActivating = 3'd1;
  localparam logic [2:0]    CsActivated  = 3'd2;
  localparam logic [CW-1:0] XMax         = CW'(GRID_W - 1);
  localparam logic [CW-1:0] YMax         = CW'(GRID_H - 1);

  typedef enum logic [2:0] {
    StIdle, StSelect, StPosRd, StPosLd, StFetch, StLatch, StWaitMove, StSolved
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    map_id_q, map_id_d;
  logic          activated_q, activated_d;
  logic          failed_q, failed_d;
  logic [CW-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [CW-1:0] goal_x_q, goal_x_d, goal_y_q, goal_y_d;
  logic [CW-1:0] start_x_q, start_x_d, start_y_q, start_y_d;
  logic [3:0]    walls_q, walls_d;
  logic [7:0]    move_count_q, move_count_d;

  // Only the low nibble of the random word selects a map.
  logic unused_rnd;
  assign unused_rnd = ^rnd_i[31:4];

  // Fixed U > D > L > R priority; lower-priority pulses in the same cycle are dropped.
  logic go_u, go_d, go_l, go_r, any_btn;
  assign go_u    = btn_u_i;
  assign go_d    = btn_d_i & ~btn_u_i;
  assign go_l    = btn_l_i & ~btn_u_i & ~btn_d_i;
  assign go_r    = btn_r_i & ~btn_u_i & ~btn_d_i & ~btn_l_i;
  assign any_btn = btn_u_i | btn_d_i | btn_l_i | btn_r_i;

  // Off-grid moves are illegal regardless of what the ROM says.
  logic blocked;
  assign blocked = (go_u & (walls_q[3] | (cur_y_q == '0))) |
                   (go_d & (walls_q[2] | (cur_y_q == YMax))) |
                   (go_l & (walls_q[1] | (cur_x_q == '0))) |
                   (go_r & (walls_q[0] | (cur_x_q == XMax)));

  logic [CW-1:0] tgt_x, tgt_y;
  always_comb begin
    tgt_x = cur_x_q;
    tgt_y = cur_y_q;
    if (go_u) tgt_y = cur_y_q - CW'(1);
    if (go_d) tgt_y = cur_y_q + CW'(1);
    if (go_l) tgt_x = cur_x_q - CW'(1);
    if (go_r) tgt_x = cur_x_q + CW'(1);
  end

  logic       at_goal, over_limit;
  logic [7:0] cnt_inc;
  assign at_goal    = (tgt_x == goal_x_q) && (tgt_y == goal_y_q);
  assign cnt_inc    = (move_count_q == 8'hFF) ? 8'hFF : move_count_q + 8'd1;
  // Reaching the goal on the last allowed move still counts as solved.
  assign over_limit = (MOVE_LIMIT != 0) && (32'(cnt_inc) > MOVE_LIMIT) && !at_goal;

  always_comb begin
    state_d      = state_q;
    map_id_d     = map_id_q;
    activated_d  = activated_q;
    failed_d     = 1'b0;
    cur_x_d      = cur_x_q;
    cur_y_d      = cur_y_q;
    goal_x_d     = goal_x_q;
    goal_y_d     = goal_y_q;
    start_x_d    = start_x_q;
    start_y_d    = start_y_q;
    walls_d      = walls_q;
    move_count_d = move_count_q;
    case (state_q)
      StIdle: begin
        if (current_state_i == CsActivating) begin
          map_id_d    = rnd_i[3:0];
          activated_d = 1'b1;
          state_d     = StSelect;
        end
      end
      StSelect: begin
        // Modulo by repeated subtraction, one step per cycle.
        if (32'(map_id_q) >= NUM_MAPS) begin
          map_id_d = map_id_q - 4'(NUM_MAPS);
        end else if (current_state_i == CsActivated) begin
          state_d = StPosRd;
        end
      end
      StPosRd: state_d = StPosLd;
      StPosLd: begin
        start_y_d    = pos_data_i[4*CW-1 -: CW];
        start_x_d    = pos_data_i[3*CW-1 -: CW];
        goal_y_d     = pos_data_i[2*CW-1 -: CW];
        goal_x_d     = pos_data_i[CW-1:0];
        cur_y_d      = pos_data_i[4*CW-1 -: CW];
        cur_x_d      = pos_data_i[3*CW-1 -: CW];
        move_count_d = '0;
        if ((pos_data_i[4*CW-1 -: CW] == pos_data_i[2*CW-1 -: CW]) &&
            (pos_data_i[3*CW-1 -: CW] == pos_data_i[CW-1:0])) begin
          state_d = StSolved;
        end else begin
          state_d = StFetch;
        end
      end
      StFetch: state_d = StLatch;
      StLatch: begin
        walls_d = wall_data_i;
        state_d = StWaitMove;
      end
      StWaitMove: begin
        if (any_btn) begin
          if (blocked || over_limit) begin
            failed_d = 1'b1;
            if (RESTART_ON_FAIL != 0) begin
              cur_x_d      = start_x_q;
              cur_y_d      = start_y_q;
              move_count_d = '0;
            end
            state_d = StFetch;
          end else begin
            cur_x_d      = tgt_x;
            cur_y_d      = tgt_y;
            move_count_d = cnt_inc;
            state_d      = at_goal ? StSolved : StFetch;
          end
        end
      end
      StSolved: state_d = StSolved;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      map_id_q     <= '0;
      activated_q  <= 1'b0;
      failed_q     <= 1'b0;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      goal_x_q     <= '0;
      goal_y_q     <= '0;
      start_x_q    <= '0;
      start_y_q    <= '0;
      walls_q      <= '0;
      move_count_q <= '0;
    end else begin
      state_q      <= state_d;
      map_id_q     <= map_id_d;
      activated_q  <= activated_d;
      failed_q     <= failed_d;
      cur_x_q      <= cur_x_d;
      cur_y_q      <= cur_y_d;
      goal_x_q     <= goal_x_d;
      goal_y_q     <= goal_y_d;
      start_x_q    <= start_x_d;
      start_y_q    <= start_y_d;
      walls_q      <= walls_d;
      move_count_q <= move_count_d;
    end
  end

  assign wall_addr_o     = 12'(32'(map_id_q) * GRID_W * GRID_H + 32'(cur_y_q) * GRID_W +
                               32'(cur_x_q));
  assign pos_addr_o      = map_id_q;
  assign activated_o     = activated_q;
  assign module_failed_o = failed_q;
  assign module_solved_o = (state_q == StSolved);
  assign cur_x_o         = cur_x_q;
  assign cur_y_o         = cur_y_q;
  assign goal_x_o        = goal_x_q;
  assign goal_y_o        = goal_y_q;
  assign move_count_o    = move_count_q;
  assign map_id_o        = map_id_q;

endmodule

// File: tb/tb_maze_engine_gen.sv
// Directed bench for maze_engine_gen. Three instances share stimulus:
//   0: defaults (unlimited moves, restart on fail)
//   1: RESTART_ON_FAIL = 0
//   2: MOVE_LIMIT = 3
// The instance under test is released from reset, the others are held in reset.
// ROM contents (8x8 grid):
//   pos  {sy,sx,gy,gx}: map0 0002, map1 0005, map2 0077, map3 0003, map4 2165, map5 3333
//   wall map2: every x=0 cell has a right wall; (0,1) also has an up wall.
module tb_maze_engine_gen;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0] rst;
  logic [2:0]    cs;
  logic [31:0]   rnd;
  logic          bu, bd, bl, br;

  logic [11:0] wall_addr [NI];
  logic [3:0]  pos_addr [NI];
  logic        activated [NI];
  logic        failed [NI];
  logic        solved [NI];
  logic [3:0]  cur_x [NI];
  logic [3:0]  cur_y [NI];
  logic [3:0]  goal_x [NI];
  logic [3:0]  goal_y [NI];
  logic [7:0]  move_count [NI];
  logic [3:0]  map_id [NI];

  int n_pass  = 0;
  int n_total = 0;
  int sel     = 0;

  function automatic logic [3:0] wall_rom(input logic [11:0] a);
    if (a[11:6] == 6'd2 && a[2:0] == 3'd0) begin
      if (a[5:3] == 3'd1) return 4'b1001;
      return 4'b0001;
    end
    return 4'b0000;
  endfunction

  function automatic logic [15:0] pos_rom(input logic [3:0] m);
    case (m)
      4'd0:    return 16'h0002;
      4'd1:    return 16'h0005;
      4'd2:    return 16'h0077;
      4'd3:    return 16'h0003;
      4'd4:    return 16'h2165;
      4'd5:    return 16'h3333;
      default: return 16'h0007;
    endcase
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [3:0]  wd;
    logic [15:0] pd;
    always_ff @(posedge clk) begin
      wd <= wall_rom(wall_addr[g]);
      pd <= pos_rom(pos_addr[g]);
    end
    maze_engine_gen #(
      .GRID_W(8), .GRID_H(8), .NUM_MAPS(9), .CW(4),
      .MOVE_LIMIT(g == 2 ? 3 : 0),
      .RESTART_ON_FAIL(g == 1 ? 0 : 1)
    ) u_dut (
      .clk_i(clk), .rst_i(rst[g]), .current_state_i(cs), .rnd_i(rnd),
      .btn_u_i(bu), .btn_d_i(bd), .btn_l_i(bl), .btn_r_i(br),
      .wall_addr_o(wall_addr[g]), .wall_data_i(wd),
      .pos_addr_o(pos_addr[g]), .pos_data_i(pd),
      .activated_o(activated[g]), .module_failed_o(failed[g]), .module_solved_o(solved[g]),
      .cur_x_o(cur_x[g]), .cur_y_o(cur_y[g]), .goal_x_o(goal_x[g]), .goal_y_o(goal_y[g]),
      .move_count_o(move_count[g]), .map_id_o(map_id[g])
    );
  end

  function automatic logic [46:0] all_outs(input int i);
    return {activated[i], failed[i], solved[i], cur_x[i], cur_y[i], goal_x[i], goal_y[i],
            move_count[i], map_id[i], wall_addr[i], pos_addr[i]};
  endfunction

  // Packed {cur_x, cur_y, move_count} of the selected instance.
  function automatic logic [15:0] pos_cnt();
    return {cur_x[sel], cur_y[sel], move_count[sel]};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic hold_reset(input int inst);
    sel = inst;
    rst = '1;
    cs  = 3'd0;
    rnd = 32'd0;
    {bu, bd, bl, br} = 4'b0000;
    tick();
    tick();
    rst[inst] = 1'b0;
    tick();
  endtask

  // rnd only matters in the first cycle; it is scrambled afterwards.
  task automatic activate(input logic [3:0] r);
    cs  = 3'd1;
    rnd = {28'h1234567, r};
    tick();
    cs  = 3'd2;
    rnd = 32'hFFFF_FFFF;
    repeat (8) tick();
  endtask

  task automatic start_game(input int inst, input logic [3:0] r);
    hold_reset(inst);
    activate(r);
  endtask

  // One pulse; f1 is module_failed in the cycle after the edge, f2 the cycle after that.
  // Returns with the engine back in its wait-for-move state.
  task automatic press(input logic u, d, l, r, output logic f1, output logic f2);
    {bu, bd, bl, br} = {u, d, l, r};
    tick();
    {bu, bd, bl, br} = 4'b0000;
    f1 = failed[sel];
    tick();
    f2 = failed[sel];
    tick();
  endtask

  task automatic test_reset();
    hold_reset(0);
    rst[0] = 1'b1;
    tick();
    n_total++;
    if (all_outs(0) !== 47'd0) $display("FAIL reset_outs: got %h want 0", all_outs(0));
    else n_pass++;
    rst[0] = 1'b0;
    repeat (3) tick();
    n_total++;
    if (activated[0] !== 1'b0) $display("FAIL idle_no_act: got %b want 0", activated[0]);
    else n_pass++;
  endtask

  task automatic test_select();
    start_game(0, 4'd13);
    n_total++;
    if (map_id[0] !== 4'd4) $display("FAIL sel_map_id: got %0d want 4", map_id[0]);
    else n_pass++;
    n_total++;
    if ({activated[0], pos_addr[0]} !== 5'b1_0100)
      $display("FAIL sel_act_addr: got %b want 10100", {activated[0], pos_addr[0]});
    else n_pass++;
    n_total++;
    if ({cur_x[0], cur_y[0], goal_x[0], goal_y[0]} !== 16'h1256)
      $display("FAIL sel_cur_goal: got %h want 1256", {cur_x[0], cur_y[0], goal_x[0], goal_y[0]});
    else n_pass++;
    n_total++;
    if (wall_addr[0] !== 12'd273) $display("FAIL sel_wall_addr: got %0d want 273", wall_addr[0]);
    else n_pass++;
  endtask

  task automatic test_legal_path();
    logic f1, f2;
    start_game(0, 4'd9);
    press(1'b0, 1'b0, 1'b0, 1'b1, f1, f2);
    n_total++;
    if ({f1, f2, pos_cnt()} !== {2'b00, 16'h1001})
      $display("FAIL path_step1: got %h want %h", {f1, f2, pos_cnt()}, {2'b00, 16'h1001});
    else n_pass++;
    cs = 3'd0;  // controller going idle must not disturb play
    press(1'b0, 1'b0, 1'b0, 1'b1, f1, f2);
    n_total++;
    if ({f1, f2, solved[0], pos_cnt()} !== {3'b001, 16'h2002})
      $display("FAIL path_solve: got %h want %h", {f1, f2, solved[0], pos_cnt()}, {3'b001, 16'h2002});
    else n_pass++;
    press(1'b0, 1'b0, 1'b1, 1'b0, f1, f2);
    press(1'b1, 1'b0, 1'b0, 1'b0, f1, f2);
    n_total++;
    if ({f1, f2, solved[0], activated[0], pos_cnt()} !== {4'b0011, 16'h2002})
      $display("FAIL solved_sticky: got %h want %h",
               {f1, f2, solved[0], activated[0], pos_cnt()}, {4'b0011, 16'h2002});
    else n_pass++;
  endtask

  task automatic test_priority_dead_time();
    logic f1, f2;
    start_game(0, 4'd0);
    press(1'b1, 1'b0, 1'b1, 1'b0, f1, f2);
    n_total++;
    if ({f1, f2, pos_cnt()} !== {2'b10, 16'h0000})
      $display("FAIL prio_ul: got %h want %h", {f1, f2, pos_cnt()}, {2'b10, 16'h0000});
    else n_pass++;
    press(1'b1, 1'b0, 1'b0, 1'b1, f1, f2);
    n_total++;
    if ({f1, pos_cnt()} !== {1'b1, 16'h0000})
      $display("FAIL prio_ur: got %h want %h", {f1, pos_cnt()}, {1'b1, 16'h0000});
    else n_pass++;
    press(1'b0, 1'b1, 1'b0, 1'b1, f1, f2);
    n_total++;
    if ({f1, pos_cnt()} !== {1'b0, 16'h0101})
      $display("FAIL prio_dr: got %h want %h", {f1, pos_cnt()}, {1'b0, 16'h0101});
    else n_pass++;
    // Legal R, then a second R one cycle later while fetching walls.
    br = 1'b1;
    tick();
    br = 1'b0;
    tick();
    br = 1'b1;
    tick();
    br = 1'b0;
    tick();
    n_total++;
    if (pos_cnt() !== 16'h1102) $display("FAIL dead_time: got %h want 1102", pos_cnt());
    else n_pass++;
    press(1'b0, 1'b1, 1'b1, 1'b0, f1, f2);
    n_total++;
    if ({f1, pos_cnt()} !== {1'b0, 16'h1203})
      $display("FAIL prio_dl: got %h want %h", {f1, pos_cnt()}, {1'b0, 16'h1203});
    else n_pass++;
  endtask

  task automatic test_wall_restart();
    logic f1, f2;
    start_game(0, 4'd2);
    press(1'b0, 1'b0, 1'b0, 1'b1, f1, f2);
    n_total++;
    if ({f1, f2, pos_cnt()} !== {2'b10, 16'h0000})
      $display("FAIL wall_right: got %h want %h", {f1, f2, pos_cnt()}, {2'b10, 16'h0000});
    else n_pass++;
    press(1'b0, 1'b1, 1'b0, 1'b0, f1, f2);
    n_total++;
    if ({f1, pos_cnt()} !== {1'b0, 16'h0101})
      $display("FAIL wall_down_ok: got %h want %h", {f1, pos_cnt()}, {1'b0, 16'h0101});
    else n_pass++;
    press(1'b1, 1'b0, 1'b0, 1'b0, f1, f2);
    n_total++;
    if ({f1, f2, pos_cnt()} !== {2'b10, 16'h0000})
      $display("FAIL wall_up_restart: got %h want %h", {f1, f2, pos_cnt()}, {2'b10, 16'h0000});
    else n_pass++;
  endtask

  task automatic test_wall_hold();
    logic f1, f2;
    start_game(1, 4'd11);
    press(1'b0, 1'b1, 1'b0, 1'b0, f1, f2);
    press(1'b0, 1'b0, 1'b0, 1'b1, f1, f2);
    n_total++;
    if ({f1, f2, map_id[1], pos_cnt()} !== {2'b10, 4'd2, 16'h0101})
      $display("FAIL wall_hold: got %h want %h",
               {f1, f2, map_id[1], pos_cnt()}, {2'b10, 4'd2, 16'h0101});
    else n_pass++;
  endtask

  task automatic test_move_limit();
    logic f1, f2;
    logic any_f;
    start_game(2, 4'd10);
    any_f = 1'b0;
    repeat (3) begin
      press(1'b0, 1'b0, 1'b0, 1'b1, f1, f2);
      any_f = any_f | f1 | f2;
    end
    n_total++;
    if ({any_f, pos_cnt()} !== {1'b0, 16'h3003})
      $display("FAIL limit_three: got %h want %h", {any_f, pos_cnt()}, {1'b0, 16'h3003});
    else n_pass++;
    press(1'b0, 1'b0, 1'b0, 1'b1, f1, f2);
    n_total++;
    if ({f1, f2, pos_cnt()} !== {2'b10, 16'h0000})
      $display("FAIL limit_over: got %h want %h", {f1, f2, pos_cnt()}, {2'b10, 16'h0000});
    else n_pass++;
    start_game(2, 4'd3);
    any_f = 1'b0;
    repeat (3) begin
      press(1'b0, 1'b0, 1'b0, 1'b1, f1, f2);
      any_f = any_f | f1 | f2;
    end
    n_total++;
    if ({any_f, solved[2], pos_cnt()} !== {2'b01, 16'h3003})
      $display("FAIL limit_exact_goal: got %h want %h",
               {any_f, solved[2], pos_cnt()}, {2'b01, 16'h3003});
    else n_pass++;
  endtask

  task automatic test_degenerate();
    logic f1, f2;
    start_game(0, 4'd5);
    press(1'b0, 1'b1, 1'b0, 1'b0, f1, f2);
    n_total++;
    if ({f1, solved[0], pos_cnt()} !== {2'b01, 16'h3300})
      $display("FAIL degenerate: got %h want %h", {f1, solved[0], pos_cnt()}, {2'b01, 16'h3300});
    else n_pass++;
  endtask

  task automatic test_reset_mid_move();
    start_game(0, 4'd0);
    br = 1'b1;
    tick();
    br = 1'b0;
    tick();
    #2 rst[0] = 1'b1;
    #1;
    n_total++;
    if (all_outs(0) !== 47'd0) $display("FAIL reset_async: got %h want 0", all_outs(0));
    else n_pass++;
    tick();
    n_total++;
    if (failed[0] !== 1'b0) $display("FAIL reset_no_fail: got %b want 0", failed[0]);
    else n_pass++;
    rst[0] = 1'b0;
    cs = 3'd0;
    tick();
    activate(4'd13);
    n_total++;
    if ({activated[0], map_id[0], cur_x[0], cur_y[0]} !== {1'b1, 12'h412})
      $display("FAIL reset_reselect: got %h want %h",
               {activated[0], map_id[0], cur_x[0], cur_y[0]}, {1'b1, 12'h412});
    else n_pass++;
  endtask

  initial begin
    rst = '1;
    cs  = 3'd0;
    rnd = 32'd0;
    {bu, bd, bl, br} = 4'b0000;
    test_reset();
    test_select();
    test_legal_path();
    test_priority_dead_time();
    test_wall_restart();
    test_wall_hold();
    test_move_limit();
    test_degenerate();
    test_reset_mid_move();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
